// File: rtl/dest_hazard_unit_if.sv
// ID-stage request and hazard-unit response bundle.
// Carries destination, stall and forwarding signals between ID and the unit.
interface dest_hazard_unit_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] id_rd;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic              id_reg_dst;
  logic              id_link;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [ADDR_W-1:0] ex_dest;
  logic [ADDR_W-1:0] mem_dest;
  logic [ADDR_W-1:0] wb_dest;
  logic              ex_reg_write;
  logic              mem_reg_write;
  logic              wb_reg_write;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_uses_rs, id_uses_rt,
    output id_reg_write, id_reg_dst,
    output id_link, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel,
    input  ex_dest, mem_dest, wb_dest,
    input  ex_reg_write, mem_reg_write,
    input  wb_reg_write, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_uses_rs, id_uses_rt,
    input  id_reg_write, id_reg_dst,
    input  id_link, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel,
    output ex_dest, mem_dest, wb_dest,
    output ex_reg_write, mem_reg_write,
    output wb_reg_write, stall_count
  );
endinterface

// File: rtl/dest_hazard_unit.sv
// Destination resolver and EX/MEM/WB tracker.
// Produces load-use stall and registered forwarding selects.
module dest_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  dest_hazard_unit_if.slave bus
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] dest;
    logic              load;
  } slot_t;

  localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

  slot_t             ex_q, mem_q, wb_q, new_e;
  logic [ADDR_W-1:0] id_dest;
  logic              rs_ex, rs_mem, rt_ex, rt_mem;
  logic              stall_c, issue;
  logic [1:0]        fa_d, fb_d, fa_q, fb_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic hit(
    input logic              use_src,
    input logic [ADDR_W-1:0] src,
    input slot_t             s
  );
    return use_src && s.we &&
           (s.dest == src) && (src != '0);
  endfunction

  always_comb begin
    id_dest = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    if (bus.id_link) id_dest = LINK;
    rs_ex  = hit(bus.id_uses_rs, bus.id_rs, ex_q);
    rs_mem = hit(bus.id_uses_rs, bus.id_rs, mem_q);
    rt_ex  = hit(bus.id_uses_rt, bus.id_rt, ex_q);
    rt_mem = hit(bus.id_uses_rt, bus.id_rt, mem_q);
    // Reset masks stall so it never shows during the reset cycle
    stall_c = !reset && bus.id_valid && !bus.flush &&
              (rs_ex || rt_ex) && ex_q.load;
    issue = bus.id_valid && !bus.flush && !stall_c;
    new_e = '0;
    fa_d  = 2'b00;
    fb_d  = 2'b00;
    if (issue) begin
      new_e.we   = bus.id_reg_write && (id_dest != '0);
      new_e.dest = id_dest;
      new_e.load = bus.id_mem_read;
      if (rs_ex)       fa_d = 2'b01;
      else if (rs_mem) fa_d = 2'b10;
      if (rt_ex)       fb_d = 2'b01;
      else if (rt_mem) fb_d = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      fa_q  <= 2'b00;
      fb_q  <= 2'b00;
      cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= new_e;
      fa_q  <= fa_d;
      fb_q  <= fb_d;
      if (stall_c && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall         = stall_c;
  assign bus.fwd_a_sel     = fa_q;
  assign bus.fwd_b_sel     = fb_q;
  assign bus.ex_dest       = ex_q.dest;
  assign bus.mem_dest      = mem_q.dest;
  assign bus.wb_dest       = wb_q.dest;
  assign bus.ex_reg_write  = ex_q.we;
  assign bus.mem_reg_write = mem_q.we;
  assign bus.wb_reg_write  = wb_q.we;
  assign bus.stall_count   = cnt_q;

endmodule
